// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared 16-bit datapath bus.
// One requester owns the bus at a time. Ownership ends on done, on a dropped
// request, or on the hold timeout. Each hand-over passes through one TURN cycle
// in which nobody drives the bus.
//
// Handshake: req is a level that the requester holds until it sees its grant
// bit. The requester keeps req high for as long as it wants the bus. A release
// is signalled either by a single-cycle done[owner] pulse or by dropping
// req[owner]. The requester must stop driving the bus in the cycle after its
// grant bit falls. Non-owner done bits are ignored.
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            bus_busy,
    output logic            timeout,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam logic [CNTW-1:0] HOLD_LIM = CNTW'(MAX_HOLD);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CNTW-1:0] hold;

    logic            any_req;
    logic [IDW-1:0]  sel;
    logic            release_now;
    logic            release_to;
    logic [IDW-1:0]  next_ptr;

    assign dbg_state = state;

    // Pick the first requester at or above ptr, wrapping modulo NREQ. The scan
    // runs from the lowest priority down, so the last hit is the winner.
    always_comb begin
        int idx;
        any_req = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                any_req = 1'b1;
                sel     = IDW'(idx);
            end
        end
    end

    // Release conditions for the current owner. done takes priority, so a done
    // in the final hold cycle never raises timeout.
    always_comb begin
        release_now = 1'b0;
        release_to  = 1'b0;
        if (done[grant_id]) begin
            release_now = 1'b1;
        end else if (!req[grant_id]) begin
            release_now = 1'b1;
        end else if (MAX_HOLD != 0 && hold == HOLD_LIM) begin
            release_now = 1'b1;
            release_to  = 1'b1;
        end
    end

    // The owner that just released becomes the lowest priority.
    always_comb begin
        next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end

    // Arbitration FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold     <= '0;
            grant    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (any_req) begin
                        grant    <= ONE_HOT0 << sel;
                        grant_id <= sel;
                        bus_busy <= 1'b1;
                        hold     <= CNTW'(1);
                        state    <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant    <= '0;
                        grant_id <= '0;
                        bus_busy <= 1'b0;
                        ptr      <= next_ptr;
                        timeout  <= release_to;
                        state    <= TURN;
                    end else if (hold != '1) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    grant    <= '0;
                    grant_id <= '0;
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for the reset, round-robin,
// request-drop and mid-grant reset cases, and hand-written loops for the hold
// timeout.
module tb_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 16;
    localparam int CNTW     = 5;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            bus_busy;
    logic            timeout;
    logic [1:0]      dbg_state;

    bus_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] exp_grant;
        logic            exp_to;
    } vec_t;

    vec_t vecs[$];

    // Scoreboard: expected {timeout, grant} pushed per step, popped on check
    logic [NREQ:0] exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [IDW-1:0] id_of(input logic [NREQ-1:0] g);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++)
            if (g[i]) r = IDW'(i);
        return r;
    endfunction

    task automatic cmp(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [NREQ-1:0] rq,
                       input logic [NREQ-1:0] dn, input logic [NREQ-1:0] g,
                       input logic to);
        vec_t v;
        v.rst = r; v.req = rq; v.done = dn; v.exp_grant = g; v.exp_to = to;
        vecs.push_back(v);
    endtask

    // Driver: apply inputs, clock once, then check outputs 1 time unit later
    task automatic step(input int id, input logic r, input logic [NREQ-1:0] rq,
                        input logic [NREQ-1:0] dn, input logic [NREQ-1:0] g,
                        input logic to);
        logic [NREQ:0] e;
        rst  = r;
        req  = rq;
        done = dn;
        exp_q.push_back({to, g});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp("grant",    id, 32'(grant),    32'(e[NREQ-1:0]));
        cmp("grant_id", id, 32'(grant_id), 32'(id_of(e[NREQ-1:0])));
        cmp("bus_busy", id, 32'(bus_busy), 32'(e[NREQ-1:0] != '0));
        cmp("timeout",  id, 32'(timeout),  32'(e[NREQ]));
        cmp("onehot0",  id, 32'($onehot0(grant)), 32'(1));
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;
        @(negedge clk);

        // Reset, then single requester with done and with req drop
        add(1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        // Round-robin from ptr 0, each owner holds 3 cycles then done
        add(1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        // ptr is 1: owner 1, late req[0]/req[3] not preempting, then drop
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b1011, 4'b1001, 4'b0010, 0);
        add(0, 4'b1001, 4'b0000, 4'b0000, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 0);
        add(0, 4'b1001, 4'b1000, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0);
        add(0, 4'b0000, 4'b0001, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        // ptr is 1: reset mid-grant returns ptr to 0
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(1, 4'b0010, 4'b0000, 4'b0000, 0);
        add(0, 4'b0110, 4'b0000, 4'b0010, 0);
        add(0, 4'b0110, 4'b0010, 4'b0000, 0);
        add(0, 4'b0110, 4'b0000, 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);

        foreach (vecs[i])
            step(i, vecs[i].rst, vecs[i].req, vecs[i].done,
                 vecs[i].exp_grant, vecs[i].exp_to);

        // Hold timeout: 16 grant cycles, timeout with grant 0, regrant
        step(100, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        for (int k = 1; k <= MAX_HOLD; k++)
            step(100 + k, 0, 4'b0100, 4'b0000, 4'b0100, 0);
        step(120, 0, 4'b0100, 4'b0000, 4'b0000, 1);
        step(121, 0, 4'b0100, 4'b0000, 4'b0100, 0);

        // done in the 16th grant cycle wins over timeout
        for (int k = 2; k <= MAX_HOLD; k++)
            step(120 + k, 0, 4'b0100, 4'b0000, 4'b0100, 0);
        step(140, 0, 4'b0100, 4'b0100, 4'b0000, 0);
        step(141, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(142, 0, 4'b0000, 4'b0000, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
